// File: rtl/uart_block_framer.sv
// Packs a UART byte stream into fixed-size plaintext blocks (byte 0 in the MSBs)
// and hands each block, with its valid-byte count, downstream over valid/ready.
`timescale 1ns/1ps
module uart_block_framer #(
  parameter int BLOCK_BYTES    = 64,
  parameter int TIMEOUT_CYCLES = 27000
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [7:0]                         in_data,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic                               flush,
  output logic [8*BLOCK_BYTES-1:0]           blk_data,
  output logic [$clog2(BLOCK_BYTES+1)-1:0]   blk_len,
  output logic                               blk_valid,
  input  logic                               blk_ready,
  output logic [15:0]                        drop_cnt
);

  localparam int CNT_W  = $clog2(BLOCK_BYTES + 1);
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BUF_W  = 8 * BLOCK_BYTES;

  logic [BUF_W-1:0]  fill_buf;
  logic [CNT_W-1:0]  fill_cnt;
  logic              commit_pend;
  logic [IDLE_W-1:0] idle_cnt;
  logic              full;
  logic              accept;
  logic              commit;
  logic [BUF_W-1:0]  fill_next;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Keeps the first n bytes (MSB side) and zeroes everything after them.
  function automatic logic [BUF_W-1:0] zero_tail(input logic [BUF_W-1:0] b,
                                                 input logic [CNT_W-1:0] n);
    return b & ~({BUF_W{1'b1}} >> (8 * n));
  endfunction

  always_comb begin
    full      = (fill_cnt == CNT_W'(BLOCK_BYTES));
    in_ready  = !full && !commit_pend;
    accept    = in_valid && in_ready;
    commit    = (full || commit_pend) && (!blk_valid || blk_ready);
    fill_next = (fill_buf & ~({8'hFF, {(BUF_W-8){1'b0}}} >> (8 * fill_cnt)))
              | ({in_data, {(BUF_W-8){1'b0}}} >> (8 * fill_cnt));
  end

  // Fill buffer data: no reset, stale bytes are masked off at commit.
  always_ff @(posedge clk) begin
    if (accept)
      fill_buf <= fill_next;
  end

  // Fill control: byte count, idle timeout and pending-commit flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_cnt    <= '0;
      commit_pend <= 1'b0;
      idle_cnt    <= '0;
    end else if (commit) begin
      fill_cnt    <= '0;
      commit_pend <= 1'b0;
      idle_cnt    <= '0;
    end else begin
      if (accept)
        fill_cnt <= fill_cnt + 1'b1;
      if (accept || fill_cnt == '0) begin
        idle_cnt <= '0;
      end else if (!commit_pend) begin
        if (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1))
          commit_pend <= 1'b1;
        idle_cnt <= idle_cnt + 1'b1;
      end
      // A byte accepted alongside the flush counts toward the closed block.
      if (flush && (accept || fill_cnt != '0))
        commit_pend <= 1'b1;
    end
  end

  // Output register: a commit and a consume in one cycle keeps blk_valid high.
  always_ff @(posedge clk) begin
    if (rst) begin
      blk_valid <= 1'b0;
      blk_data  <= '0;
      blk_len   <= '0;
    end else if (commit) begin
      blk_valid <= 1'b1;
      blk_data  <= zero_tail(fill_buf, fill_cnt);
      blk_len   <= fill_cnt;
    end else if (blk_valid && blk_ready) begin
      blk_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      drop_cnt <= '0;
    else if (in_valid && !in_ready)
      drop_cnt <= sat_inc16(drop_cnt);
  end

endmodule

// File: tb/tb_uart_block_framer.sv
// Scoreboard bench for uart_block_framer: expected blocks are queued as bytes
// are driven and popped when the framer presents a block.
`timescale 1ns/1ps
module tb_uart_block_framer;

  localparam int BB = 64;
  localparam int TO = 100;
  localparam int BW = 8 * BB;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          flush = 1'b0;
  logic [BW-1:0] blk_data;
  logic [6:0]    blk_len;
  logic          blk_valid;
  logic          blk_ready = 1'b0;
  logic [15:0]   drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [BW-1:0] exp_data_q[$];
  int            exp_len_q[$];
  logic [BW-1:0] acc;
  int            acc_n;

  always #5 clk = ~clk;

  uart_block_framer #(.BLOCK_BYTES(BB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .blk_data(blk_data),
    .blk_len(blk_len), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .drop_cnt(drop_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic acc_clear();
    acc   = '0;
    acc_n = 0;
  endtask

  task automatic acc_add(input logic [7:0] b);
    acc   = acc | ({b, {(BW-8){1'b0}}} >> (8 * acc_n));
    acc_n = acc_n + 1;
  endtask

  task automatic acc_push();
    exp_data_q.push_back(acc);
    exp_len_q.push_back(acc_n);
    acc_clear();
  endtask

  task automatic drive_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    n_checks++; if (blk_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", blk_valid); end
    n_checks++; if (blk_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", blk_data); end
    n_checks++; if (blk_len !== 7'd0) begin n_fail++; $display("FAIL reset_len: got %0d want 0", blk_len); end
    n_checks++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
    rst = 1'b0;
    tick();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
  endtask

  task automatic test_full_block();
    logic [BW-1:0] ed;
    int el;
    blk_ready = 1'b1;
    acc_clear();
    for (int i = 0; i < BB; i++) begin
      acc_add(8'(i));
      drive_byte(8'(i));
    end
    acc_push();
    n_checks++; if (blk_valid !== 1'b0) begin n_fail++; $display("FAIL full_early_valid: got %0b want 0", blk_valid); end
    tick();
    n_checks++; if (blk_valid !== 1'b1) begin n_fail++; $display("FAIL full_valid: got %0b want 1", blk_valid); end
    n_checks++;
    if (exp_data_q.size() == 0) begin
      n_fail++; $display("FAIL full_sb: queue empty, want 1 entry");
    end else begin
      ed = exp_data_q.pop_front();
      el = exp_len_q.pop_front();
      if (blk_data !== ed) begin n_fail++; $display("FAIL full_data: got %h want %h", blk_data, ed); end
      n_checks++; if (blk_len !== 7'(el)) begin n_fail++; $display("FAIL full_len: got %0d want %0d", blk_len, el); end
    end
    n_checks++; if (blk_data[511:504] !== 8'h00 || blk_data[7:0] !== 8'h3F) begin n_fail++; $display("FAIL full_ends: got %h/%h want 00/3f", blk_data[511:504], blk_data[7:0]); end
    n_checks++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL full_drop: got %0d want 0", drop_cnt); end
    tick();
    n_checks++; if (blk_valid !== 1'b0) begin n_fail++; $display("FAIL full_consume: got %0b want 0", blk_valid); end
  endtask

  task automatic test_timeout();
    logic [BW-1:0] ed;
    int el;
    int k;
    int highs;
    blk_ready = 1'b1;
    acc_clear();
    for (int i = 0; i < 5; i++) begin
      acc_add(8'(8'hA1 + i));
      drive_byte(8'(8'hA1 + i));
    end
    acc_push();
    k = 0;
    while (blk_valid !== 1'b1 && k < 300) begin
      tick();
      k++;
    end
    n_checks++; if (k != TO + 1) begin n_fail++; $display("FAIL timeout_latency: got %0d cycles want %0d", k, TO + 1); end
    n_checks++;
    if (exp_data_q.size() == 0) begin
      n_fail++; $display("FAIL timeout_sb: queue empty, want 1 entry");
    end else begin
      ed = exp_data_q.pop_front();
      el = exp_len_q.pop_front();
      if (blk_data !== ed) begin n_fail++; $display("FAIL timeout_data: got %h want %h", blk_data, ed); end
      n_checks++; if (blk_len !== 7'(el)) begin n_fail++; $display("FAIL timeout_len: got %0d want %0d", blk_len, el); end
    end
    highs = 0;
    for (int i = 0; i < 250; i++) begin
      tick();
      if (blk_valid === 1'b1) highs++;
    end
    n_checks++; if (highs != 0) begin n_fail++; $display("FAIL timeout_empty_idle: got %0d valid cycles want 0", highs); end
  endtask

  task automatic test_flush();
    logic [BW-1:0] ed;
    int el;
    int highs;
    blk_ready = 1'b1;
    acc_clear();
    for (int i = 0; i < 3; i++) begin
      acc_add(8'(8'hB1 + i));
      drive_byte(8'(8'hB1 + i));
    end
    acc_add(8'hB4);
    acc_push();
    in_valid = 1'b1;
    in_data  = 8'hB4;
    flush    = 1'b1;
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
    n_checks++; if (blk_valid !== 1'b0) begin n_fail++; $display("FAIL flush_early_valid: got %0b want 0", blk_valid); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %0b want 0", in_ready); end
    tick();
    n_checks++; if (blk_valid !== 1'b1) begin n_fail++; $display("FAIL flush_valid: got %0b want 1", blk_valid); end
    n_checks++;
    if (exp_data_q.size() == 0) begin
      n_fail++; $display("FAIL flush_sb: queue empty, want 1 entry");
    end else begin
      ed = exp_data_q.pop_front();
      el = exp_len_q.pop_front();
      if (blk_data !== ed) begin n_fail++; $display("FAIL flush_data: got %h want %h", blk_data, ed); end
      n_checks++; if (blk_len !== 7'(el)) begin n_fail++; $display("FAIL flush_len: got %0d want %0d", blk_len, el); end
    end
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    highs = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (blk_valid === 1'b1) highs++;
    end
    n_checks++; if (highs != 0) begin n_fail++; $display("FAIL flush_empty: got %0d valid cycles want 0", highs); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_empty_ready: got %0b want 1", in_ready); end
  endtask

  task automatic test_back_to_back();
    logic [BW-1:0] ed;
    blk_ready = 1'b0;
    acc_clear();
    for (int i = 0; i < BB; i++) acc_add(8'(i + 8'h40));
    acc_push();
    for (int i = BB + 1; i < 2 * BB + 1; i++) acc_add(8'(i + 8'h40));
    acc_push();
    for (int i = 0; i < 130; i++) drive_byte(8'(i + 8'h40));
    n_checks++; if (blk_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %0b want 1", blk_valid); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %0b want 0", in_ready); end
    n_checks++; if (drop_cnt !== 16'd2) begin n_fail++; $display("FAIL bp_drop: got %0d want 2", drop_cnt); end
    repeat (3) tick();
    n_checks++;
    if (exp_data_q.size() < 2) begin
      n_fail++; $display("FAIL bp_sb: queue size %0d want 2", exp_data_q.size());
    end else begin
      if (blk_data !== exp_data_q[0]) begin n_fail++; $display("FAIL bp_hold_data: got %h want %h", blk_data, exp_data_q[0]); end
      n_checks++; if (blk_len !== 7'd64) begin n_fail++; $display("FAIL bp_hold_len: got %0d want 64", blk_len); end
      blk_ready = 1'b1;
      tick();
      ed = exp_data_q.pop_front();
      void'(exp_len_q.pop_front());
      ed = exp_data_q.pop_front();
      void'(exp_len_q.pop_front());
      n_checks++; if (blk_valid !== 1'b1) begin n_fail++; $display("FAIL bp_swap_valid: got %0b want 1", blk_valid); end
      n_checks++; if (blk_data !== ed) begin n_fail++; $display("FAIL bp_swap_data: got %h want %h", blk_data, ed); end
      tick();
      n_checks++; if (blk_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %0b want 0", blk_valid); end
    end
  endtask

  task automatic test_reset_mid();
    logic [BW-1:0] ed;
    int el;
    blk_ready = 1'b0;
    for (int i = 0; i < BB; i++) drive_byte(8'(i ^ 8'h33));
    tick();
    for (int i = 0; i < 30; i++) drive_byte(8'(i ^ 8'hCC));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (blk_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %0b want 0", blk_valid); end
    n_checks++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL rstmid_drop: got %0d want 0", drop_cnt); end
    n_checks++; if (blk_data !== '0) begin n_fail++; $display("FAIL rstmid_data: got %h want 0", blk_data); end
    blk_ready = 1'b1;
    acc_clear();
    for (int i = 0; i < BB; i++) begin
      acc_add(8'(i * 3 + 7));
      drive_byte(8'(i * 3 + 7));
    end
    acc_push();
    tick();
    n_checks++; if (blk_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_new_valid: got %0b want 1", blk_valid); end
    n_checks++;
    if (exp_data_q.size() == 0) begin
      n_fail++; $display("FAIL rstmid_sb: queue empty, want 1 entry");
    end else begin
      ed = exp_data_q.pop_front();
      el = exp_len_q.pop_front();
      if (blk_data !== ed) begin n_fail++; $display("FAIL rstmid_new_data: got %h want %h", blk_data, ed); end
      n_checks++; if (blk_len !== 7'(el)) begin n_fail++; $display("FAIL rstmid_new_len: got %0d want %0d", blk_len, el); end
    end
    tick();
  endtask

  task automatic test_drop_saturation();
    blk_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h5A;
    repeat (130 + 1000) tick();
    n_checks++; if (drop_cnt !== 16'd1002) begin n_fail++; $display("FAIL drop_count: got %0d want 1002", drop_cnt); end
    repeat (70000) tick();
    in_valid = 1'b0;
    n_checks++; if (drop_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL drop_saturate: got %h want ffff", drop_cnt); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL drop_in_ready: got %0b want 0", in_ready); end
  endtask

  initial begin
    test_reset();
    test_full_block();
    test_timeout();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    test_drop_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1, "watchdog expired");
  end

endmodule
